gshare_ctrl: RTL and testbench

Sequencing and arbitration controller for the 16-entry gshare branch history table (BHT). It accepts prediction lookups from fetch and outcome resolutions from execute, and shares the single BHT read port between them. It tracks in-flight branches in an in-order queue and performs a read-modify-write 2-bit saturating update per resolved branch. It also owns the global history register (GHR), including speculative update and misprediction repair.

---
 rtl/gshare_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gshare_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_ctrl.sv
// gshare_ctrl: sequencing and arbitration for a 16-entry gshare BHT.
// Shares the single BHT read port between fetch lookups and execute
// resolutions, tracks in-flight branches in an in-order queue, and performs
// a read-modify-write 2-bit saturating counter update per resolved branch.
//
// Optional feature macro: GSHARE_SPEC_GHR_EN
//   defined   - speculative GHR update on lookup, repair and flush on mispredict
//   undefined - GHR shifts in the resolved outcome; no flush
//
// state | meaning
// IDLE  | no BHT write pending this cycle
// UPD   | BHT write of the latched counter is performed this cycle
module gshare_ctrl #(
  parameter  int IDX_W = 4,
  parameter  int PC_W  = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_ready_o,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  output logic             res_ready_o,
  output logic [IDX_W-1:0] bht_rd_idx_o,
  input  logic [1:0]       bht_rd_data_i,
  output logic             bht_wr_en_o,
  output logic [IDX_W-1:0] bht_wr_idx_o,
  output logic [1:0]       bht_wr_data_o,
  output logic [IDX_W-1:0] ghr_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             mispredict_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] UPD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic [1:0]       upd_ctr_q, upd_ctr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;

  logic [IDX_W-1:0] q_idx_q  [DEPTH];
  logic             q_pred_q [DEPTH];
  logic [IDX_W-1:0] q_ghr_q  [DEPTH];

  logic             res_acc;
  logic             pred_acc;
  logic             wr_en;
  logic [1:0]       wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_ctr;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic [IDX_W-1:0] head_ghr;
  logic             mis;

  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_pred = q_pred_q[rd_ptr_q];
  assign head_ghr  = q_ghr_q[rd_ptr_q];

  // Arbitration: a resolve always wins the read port, lookups stall behind it
  assign res_acc  = res_valid_i && (count_q != '0);
  assign pred_acc = pred_valid_i && (count_q < CNT_W'(DEPTH)) && !res_acc;
  assign wr_en    = (state_q == UPD);
  assign mis      = res_acc && (res_taken_i != head_pred);

  // Saturating +/-1 of the latched counter for the write-back cycle
  always_comb begin
    wr_data = upd_ctr_q;
    if (upd_taken_q) begin
      if (upd_ctr_q != 2'b11) wr_data = upd_ctr_q + 2'b01;
    end else begin
      if (upd_ctr_q != 2'b00) wr_data = upd_ctr_q - 2'b01;
    end
  end

  // Read-port address mux and forwarding of the in-flight write
  always_comb begin
    rd_idx = '0;
    if (res_acc)       rd_idx = head_idx;
    else if (pred_acc) rd_idx = pred_pc_i[IDX_W-1:0] ^ ghr_q;
    rd_ctr = (wr_en && (rd_idx == upd_idx_q)) ? wr_data : bht_rd_data_i;
  end

  // Next-state logic for FSM, queue pointers, occupancy and GHR
  always_comb begin
    state_d      = state_q;
    ghr_d        = ghr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    upd_idx_d    = upd_idx_q;
    upd_ctr_d    = upd_ctr_q;
    upd_taken_d  = upd_taken_q;
    mispredict_d = mis;
    if (res_acc) begin
      state_d     = UPD;
      upd_idx_d   = head_idx;
      upd_ctr_d   = rd_ctr;
      upd_taken_d = res_taken_i;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      count_d     = count_q - CNT_W'(1);
`ifdef GSHARE_SPEC_GHR_EN
      if (mis) begin
        // Repair history from the snapshot and drop every younger branch
        ghr_d    = {head_ghr[IDX_W-2:0], res_taken_i};
        count_d  = '0;
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
      end
`else
      ghr_d = {ghr_q[IDX_W-2:0], res_taken_i};
`endif
    end else begin
      state_d = IDLE;
      if (pred_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
`ifdef GSHARE_SPEC_GHR_EN
        ghr_d = {ghr_q[IDX_W-2:0], rd_ctr[1]};
`endif
      end
    end
  end

  // Control registers; a reset drops any pending write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ghr_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      upd_idx_q    <= '0;
      upd_ctr_q    <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ghr_q        <= ghr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      upd_idx_q    <= upd_idx_d;
      upd_ctr_q    <= upd_ctr_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk_i) begin
    if (pred_acc) begin
      q_idx_q[wr_ptr_q]  <= rd_idx;
      q_pred_q[wr_ptr_q] <= rd_ctr[1];
      q_ghr_q[wr_ptr_q]  <= ghr_q;
    end
  end

`ifdef GSHARE_SPEC_GHR_EN
  logic unused_bits;
  assign unused_bits = ^pred_pc_i[PC_W-1:IDX_W];
`else
  logic unused_bits;
  assign unused_bits = ^{pred_pc_i[PC_W-1:IDX_W], head_ghr};
`endif

  assign pred_ready_o  = pred_acc;
  assign pred_taken_o  = pred_acc ? rd_ctr[1] : 1'b0;
  assign res_ready_o   = res_acc;
  assign bht_rd_idx_o  = rd_idx;
  assign bht_wr_en_o   = wr_en;
  assign bht_wr_idx_o  = upd_idx_q;
  assign bht_wr_data_o = wr_data;
  assign ghr_o         = ghr_q;
  assign inflight_o    = count_q;
  assign mispredict_o  = mispredict_q;

endmodule

// File: tb/tb_gshare_ctrl.sv
// Directed bench for gshare_ctrl with a behavioural 16-entry BHT.
module tb_gshare_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_ready, pred_taken;
  logic [7:0] pred_pc;
  logic       res_valid, res_taken, res_ready;
  logic [3:0] bht_rd_idx, bht_wr_idx, ghr;
  logic [1:0] bht_rd_data, bht_wr_data;
  logic       bht_wr_en, mispredict;
  logic [2:0] inflight;

  logic [1:0] bht [16];
  logic       preload;
  logic [1:0] preload_val;
  logic [7:0] pc2;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 16; i++) bht[i] <= preload_val;
    else if (bht_wr_en) bht[bht_wr_idx] <= bht_wr_data;
  end
  assign bht_rd_data = bht[bht_rd_idx];

  gshare_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_ready_o(pred_ready), .pred_taken_o(pred_taken),
    .res_valid_i(res_valid), .res_taken_i(res_taken), .res_ready_o(res_ready),
    .bht_rd_idx_o(bht_rd_idx), .bht_rd_data_i(bht_rd_data),
    .bht_wr_en_o(bht_wr_en), .bht_wr_idx_o(bht_wr_idx), .bht_wr_data_o(bht_wr_data),
    .ghr_o(ghr), .inflight_o(inflight), .mispredict_o(mispredict)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] val);
    pred_valid = 0; res_valid = 0; res_taken = 0; pred_pc = 0;
    rst_n = 0; preload = 1; preload_val = val;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; preload = 0;
  endtask

  initial begin
    do_reset(2'b01);
    chk("rst_ghr", 8'(ghr), 8'h0);
    chk("rst_inflight", 8'(inflight), 8'h0);
    chk("rst_mispredict", 8'(mispredict), 8'h0);
    chk("rst_wr_en", 8'(bht_wr_en), 8'h0);

    // resolve while empty is ignored
    res_valid = 1; res_taken = 1; #1;
    chk("empty_res_ready", 8'(res_ready), 8'h0);
    chk("empty_rd_idx", 8'(bht_rd_idx), 8'h0);
    step(); res_valid = 0; #1;
    chk("empty_inflight", 8'(inflight), 8'h0);
    chk("empty_wr_en", 8'(bht_wr_en), 8'h0);

    // lookup pc=05 with counters at 01
    pred_valid = 1; pred_pc = 8'h05; #1;
    chk("lk_ready", 8'(pred_ready), 8'h1);
    chk("lk_rd_idx", 8'(bht_rd_idx), 8'h5);
    chk("lk_taken", 8'(pred_taken), 8'h0);
    step(); pred_valid = 0; #1;
    chk("lk_inflight", 8'(inflight), 8'h1);

    // resolve taken -> write 10 and mispredict pulse next cycle
    res_valid = 1; res_taken = 1; #1;
    chk("rs_ready", 8'(res_ready), 8'h1);
    chk("rs_rd_idx", 8'(bht_rd_idx), 8'h5);
    step(); res_valid = 0; #1;
    chk("rs_wr_en", 8'(bht_wr_en), 8'h1);
    chk("rs_wr_idx", 8'(bht_wr_idx), 8'h5);
    chk("rs_wr_data", 8'(bht_wr_data), 8'h2);
    chk("rs_mispredict", 8'(mispredict), 8'h1);
    chk("rs_inflight", 8'(inflight), 8'h0);
    chk("rs_ghr", 8'(ghr), 8'h1);
    step();
    chk("rs_wr_en_off", 8'(bht_wr_en), 8'h0);
    chk("rs_mis_off", 8'(mispredict), 8'h0);
    chk("rs_bht5", 8'(bht[5]), 8'h2);

    // saturation: two taken resolves on idx 3 with counters at 11
    do_reset(2'b11);
`ifdef GSHARE_SPEC_GHR_EN
    pc2 = 8'h02;
`else
    pc2 = 8'h03;
`endif
    pred_valid = 1; pred_pc = 8'h03; #1;
    chk("sat_lk1_taken", 8'(pred_taken), 8'h1);
    step(); pred_pc = pc2; #1;
    chk("sat_lk2_idx", 8'(bht_rd_idx), 8'h3);
    step(); pred_valid = 0;
    res_valid = 1; res_taken = 1;
    step();
    chk("sat_res2_ready", 8'(res_ready), 8'h1);
    chk("sat_w1_en", 8'(bht_wr_en), 8'h1);
    chk("sat_w1_idx", 8'(bht_wr_idx), 8'h3);
    chk("sat_w1_data", 8'(bht_wr_data), 8'h3);
    step(); res_valid = 0; #1;
    chk("sat_w2_en", 8'(bht_wr_en), 8'h1);
    chk("sat_w2_data", 8'(bht_wr_data), 8'h3);
    chk("sat_mis", 8'(mispredict), 8'h0);
    chk("sat_inflight", 8'(inflight), 8'h0);
    step();
    chk("sat_wr_en_off", 8'(bht_wr_en), 8'h0);

`ifndef GSHARE_SPEC_GHR_EN
    // forwarding: 01 -> 10 -> 11 on back-to-back resolves of idx 3
    do_reset(2'b01);
    pred_valid = 1; pred_pc = 8'h03;
    step(); step(); pred_valid = 0;
    res_valid = 1; res_taken = 1;
    step();
    chk("fwd_w1_data", 8'(bht_wr_data), 8'h2);
    step(); res_valid = 0; #1;
    chk("fwd_w2_data", 8'(bht_wr_data), 8'h3);
    step();
    chk("fwd_bht3", 8'(bht[3]), 8'h3);
`endif

    // fill to DEPTH, then resolve beats lookup
    do_reset(2'b01);
    pred_valid = 1; pred_pc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_ready", 8'(pred_ready), 8'h1);
      step();
    end
    #1;
    chk("full_ready", 8'(pred_ready), 8'h0);
    chk("full_inflight", 8'(inflight), 8'h4);
    step();
    chk("full_hold", 8'(inflight), 8'h4);
    res_valid = 1; res_taken = 0; #1;
    chk("prio_res_ready", 8'(res_ready), 8'h1);
    chk("prio_pred_ready", 8'(pred_ready), 8'h0);
    step(); res_valid = 0; pred_valid = 0; #1;
    chk("prio_inflight", 8'(inflight), 8'h3);
    chk("prio_mis", 8'(mispredict), 8'h0);

    // mispredict with older history snapshot, then reset mid-UPD
    do_reset(2'b11);
    pred_valid = 1; pred_pc = 8'h00;
    step(); pred_valid = 0;
    res_valid = 1; res_taken = 1;
    step(); res_valid = 0; #1;
    chk("mp_pre_mis", 8'(mispredict), 8'h0);
    chk("mp_pre_ghr", 8'(ghr), 8'h1);
    pred_valid = 1; #1;
    chk("mp_lk_taken", 8'(pred_taken), 8'h1);
    step(); step(); step(); pred_valid = 0; #1;
    chk("mp_inflight3", 8'(inflight), 8'h3);
    res_valid = 1; res_taken = 0; #1;
    chk("mp_rd_idx", 8'(bht_rd_idx), 8'h1);
    step(); res_valid = 0; #1;
    chk("mp_mis", 8'(mispredict), 8'h1);
    chk("mp_wr_en", 8'(bht_wr_en), 8'h1);
    chk("mp_wr_idx", 8'(bht_wr_idx), 8'h1);
    chk("mp_wr_data", 8'(bht_wr_data), 8'h2);
    chk("mp_ghr", 8'(ghr), 8'h2);
`ifdef GSHARE_SPEC_GHR_EN
    chk("mp_inflight", 8'(inflight), 8'h0);
`else
    chk("mp_inflight", 8'(inflight), 8'h2);
`endif
    step();
    chk("mp_single_write", 8'(bht_wr_en), 8'h0);
    chk("mp_mis_off", 8'(mispredict), 8'h0);
    pred_valid = 1; pred_pc = 8'h00;
    step(); pred_valid = 0;
    res_valid = 1; res_taken = 0;
    step(); res_valid = 0; #1;
    chk("rmid_wr_en_pre", 8'(bht_wr_en), 8'h1);
    chk("rmid_mis_pre", 8'(mispredict), 8'h1);
    rst_n = 0; #1;
    chk("rmid_wr_en", 8'(bht_wr_en), 8'h0);
    chk("rmid_ghr", 8'(ghr), 8'h0);
    chk("rmid_inflight", 8'(inflight), 8'h0);
    chk("rmid_mis", 8'(mispredict), 8'h0);
    step();
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
